// File: rtl/axis_keep_pkg.sv
// Shared tkeep <-> byte-count semantics for the AXI-Stream datapath.
// Checksum, framing and the converter all call these functions so they agree exactly.
package axis_keep_pkg;

  localparam int KEEP_W_DEF = 8;
  localparam int CNT_W_DEF  = 4;

  // Widest forms the functions accept; callers zero-extend into these and slice back.
  localparam int KEEP_MAX_W = 16;
  localparam int CNT_MAX_W  = 8;

  typedef logic [KEEP_MAX_W-1:0] keep_max_t;
  typedef logic [CNT_MAX_W-1:0]  cnt_max_t;

  // Popcount: non-contiguous masks are counted bit by bit, no error indication.
  function automatic cnt_max_t f_keep_to_cnt(input keep_max_t keep);
    cnt_max_t sum;
    sum = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      sum = sum + {{(CNT_MAX_W-1){1'b0}}, keep[i]};
    end
    return sum;
  endfunction

  // Lane i is enabled iff i < cnt; counts past the lane count saturate to all ones
  // once the caller truncates the result to its own width.
  function automatic keep_max_t f_cnt_to_keep(input cnt_max_t cnt);
    keep_max_t mask;
    mask = '0;
    for (int i = 0; i < KEEP_MAX_W; i++) begin
      mask[i] = (i < int'(cnt));
    end
    return mask;
  endfunction

endpackage

// File: rtl/keep_cnt_comb.sv
// Purely combinational tkeep -> count and count -> tkeep conversion.
// Legal ranges: KEEP_W 1..16, CNT_W up to 8 with 2**CNT_W > KEEP_W.
module keep_cnt_comb
  import axis_keep_pkg::*;
#(
  parameter int KEEP_W = KEEP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic [KEEP_W-1:0] keep,
  input  logic [CNT_W-1:0]  cnt,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [KEEP_W-1:0] keep_o
);

  keep_max_t keep_ext;
  cnt_max_t  cnt_ext;
  cnt_max_t  cnt_full;
  keep_max_t keep_full;

  always_comb begin
    keep_ext               = '0;
    keep_ext[KEEP_W-1:0]   = keep;
    cnt_ext                = '0;
    cnt_ext[CNT_W-1:0]     = cnt;
    cnt_full               = f_keep_to_cnt(keep_ext);
    keep_full              = f_cnt_to_keep(cnt_ext);
  end

  // Popcount never exceeds KEEP_W, which fits in CNT_W bits, so the slice is lossless.
  assign cnt_o  = cnt_full[CNT_W-1:0];
  assign keep_o = keep_full[KEEP_W-1:0];

endmodule

// File: rtl/keep_cnt_conv.sv
// Bidirectional tkeep/byte-count converter with zero-latency outputs and
// one-cycle registered copies qualified by q_valid.
module keep_cnt_conv
  import axis_keep_pkg::*;
#(
  parameter int KEEP_W = KEEP_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              mm2s_clk,
  input  logic              mm2s_reset,
  input  logic [KEEP_W-1:0] keep,
  input  logic [CNT_W-1:0]  cnt,
  input  logic              in_valid,
  output logic [CNT_W-1:0]  cnt_o,
  output logic [KEEP_W-1:0] keep_o,
  output logic [CNT_W-1:0]  cnt_q,
  output logic [KEEP_W-1:0] keep_q,
  output logic              q_valid
);

  logic [CNT_W-1:0]  cnt_d;
  logic [KEEP_W-1:0] keep_d;
  logic              valid_d;
  logic              valid_q;

  keep_cnt_comb #(
    .KEEP_W (KEEP_W),
    .CNT_W  (CNT_W)
  ) u_comb (
    .keep   (keep),
    .cnt    (cnt),
    .cnt_o  (cnt_o),
    .keep_o (keep_o)
  );

  // Data loads every cycle regardless of in_valid; consumers gate on q_valid.
  always_comb begin
    cnt_d   = cnt_o;
    keep_d  = keep_o;
    valid_d = in_valid;
  end

  always_ff @(posedge mm2s_clk) begin
    if (mm2s_reset) begin
      cnt_q   <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

  assign q_valid = valid_q;

endmodule

// File: tb/tb_keep_cnt_conv.sv
// Self-checking bench for keep_cnt_conv against a popcount / saturating-mask model.
module tb_keep_cnt_conv;

  logic       mm2s_clk;
  logic       mm2s_reset;
  logic [7:0] keep;
  logic [3:0] cnt;
  logic       in_valid;
  logic [3:0] cnt_o;
  logic [7:0] keep_o;
  logic [3:0] cnt_q;
  logic [7:0] keep_q;
  logic       q_valid;

  int n_vec;
  int n_err;

  keep_cnt_conv #(.KEEP_W(8), .CNT_W(4)) dut (
    .mm2s_clk   (mm2s_clk),
    .mm2s_reset (mm2s_reset),
    .keep       (keep),
    .cnt        (cnt),
    .in_valid   (in_valid),
    .cnt_o      (cnt_o),
    .keep_o     (keep_o),
    .cnt_q      (cnt_q),
    .keep_q     (keep_q),
    .q_valid    (q_valid)
  );

  initial mm2s_clk = 1'b0;
  always #5 mm2s_clk = ~mm2s_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_cnt(input logic [7:0] k);
    return 4'($countones(k));
  endfunction

  function automatic logic [7:0] model_mask(input logic [3:0] c);
    int n;
    n = (c > 4'd8) ? 8 : int'(c);
    return 8'((1 << n) - 1);
  endfunction

  // One cycle: drive at negedge, check combinational outputs, then registered ones after the edge.
  task automatic apply(input logic [7:0] k, input logic [3:0] c, input logic v, input logic r);
    logic [3:0] ec;
    logic [7:0] ek;
    @(negedge mm2s_clk);
    keep = k; cnt = c; in_valid = v; mm2s_reset = r;
    ec = model_cnt(k);
    ek = model_mask(c);
    #1;
    chk("cnt_o", 32'(cnt_o), 32'(ec));
    chk("keep_o", 32'(keep_o), 32'(ek));
    @(posedge mm2s_clk);
    #1;
    chk("cnt_q", 32'(cnt_q), 32'(r ? 4'd0 : ec));
    chk("keep_q", 32'(keep_q), 32'(r ? 8'd0 : ek));
    chk("q_valid", 32'(q_valid), 32'(r ? 1'b0 : v));
    $display("vec keep=%02h cnt=%0d vld=%0b rst=%0b -> cnt_o=%0d keep_o=%02h cnt_q=%0d keep_q=%02h q_valid=%0b",
             k, c, v, r, cnt_o, keep_o, cnt_q, keep_q, q_valid);
  endtask

  initial begin
    logic [7:0] m;
    n_vec = 0;
    n_err = 0;
    keep = '0; cnt = '0; in_valid = 1'b0; mm2s_reset = 1'b1;

    // Reset state, then reset dominating a live valid input.
    apply(8'h00, 4'd0, 1'b0, 1'b1);
    apply(8'hFF, 4'd8, 1'b1, 1'b1);
    apply(8'hFF, 4'd8, 1'b1, 1'b0);

    // Spot checks and exhaustive sweeps.
    apply(8'h81, 4'd3, 1'b1, 1'b0);
    for (int i = 0; i < 256; i++) apply(8'(i), 4'(i % 16), 1'(i % 2), 1'b0);
    for (int i = 0; i < 16; i++)  apply(8'($urandom), 4'(i), 1'b1, 1'b0);

    // Registered path: valid then invalid with data still updating.
    apply(8'h3F, 4'd5, 1'b1, 1'b0);
    apply(8'h0F, 4'd2, 1'b0, 1'b0);

    // Round trips through the DUT's two directions.
    for (int j = 0; j <= 8; j++) begin
      m = 8'((1 << j) - 1);
      @(negedge mm2s_clk);
      keep = m;
      #1;
      cnt = cnt_o;
      #1;
      chk("rt_keep", 32'(keep_o), 32'(m));
      cnt = 4'(j);
      #1;
      keep = keep_o;
      #1;
      chk("rt_cnt", 32'(cnt_o), 32'(j));
    end

    // Mid-stream reset and back-to-back random streaming.
    apply(8'hA5, 4'd6, 1'b1, 1'b0);
    apply(8'h5A, 4'd7, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) apply(8'($urandom), 4'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 200; i++)
      apply(8'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
